// File: rtl/spi_ctrl_if.sv
// Requester-side bus of the SPI byte controller: two request ports plus the
// shared result byte and busy flag.
interface spi_ctrl_if;
  logic       req0;
  logic       req1;
  logic       hold0;
  logic       hold1;
  logic [7:0] d0;
  logic [7:0] d1;
  logic       ack0;
  logic       ack1;
  logic [7:0] q;
  logic       busy;

  modport master (
    output req0, req1, hold0, hold1, d0, d1,
    input  ack0, ack1, q, busy
  );

  modport slave (
    input  req0, req1, hold0, hold1, d0, d1,
    output ack0, ack1, q, busy
  );
endinterface

// File: rtl/spi_ctrl.sv
// Two-port byte-transfer controller in front of the SD-card SPI byte engine:
// divider, post-reset guard, arbitration with chip-select locking, completion.
module spi_ctrl #(
  parameter int DIV = 4
) (
  input  logic       clock,
  input  logic       reset,
  spi_ctrl_if.slave  bus,
  output logic       cs,
  output logic       spi_ce,
  output logic       spi_io,
  output logic [7:0] spi_d,
  input  logic [7:0] spi_q
);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  localparam logic [7:0] DIV_LAST    = 8'(DIV - 1);
  localparam logic [4:0] GUARD_TICKS = 5'd17;

  state_t     state, state_n;
  logic [7:0] div_cnt;
  logic [4:0] guard_cnt;
  logic       guard_active;
  logic       owner, owner_n;
  logic       last, last_n;
  logic       lock, lock_n;
  logic       cs_n;
  logic [7:0] spi_d_n;
  logic [4:0] tick, tick_n;
  logic [7:0] q_r, q_n;
  logic [1:0] reqv, holdv, cand;
  logic       grant_port;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                   div_cnt <= '0;
    else if (div_cnt == DIV_LAST) div_cnt <= '0;
    else                          div_cnt <= div_cnt + 8'd1;
  end

  assign spi_ce = (div_cnt == DIV_LAST);

  // The engine has no reset, so let any in-flight byte drain before granting.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                      guard_cnt <= '0;
    else if (guard_active && spi_ce) guard_cnt <= guard_cnt + 5'd1;
  end

  assign guard_active = (guard_cnt != GUARD_TICKS);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      owner <= 1'b0;
      last  <= 1'b1;
      lock  <= 1'b0;
      cs    <= 1'b1;
      spi_d <= 8'hFF;
      tick  <= '0;
      q_r   <= 8'hFF;
    end else begin
      state <= state_n;
      owner <= owner_n;
      last  <= last_n;
      lock  <= lock_n;
      cs    <= cs_n;
      spi_d <= spi_d_n;
      tick  <= tick_n;
      q_r   <= q_n;
    end
  end

  assign reqv  = {bus.req1, bus.req0};
  assign holdv = {bus.hold1, bus.hold0};
  assign cand  = reqv & (lock ? (owner ? 2'b10 : 2'b01) : 2'b11);

  always_comb begin
    state_n    = state;
    owner_n    = owner;
    last_n     = last;
    lock_n     = lock;
    cs_n       = cs;
    spi_d_n    = spi_d;
    tick_n     = tick;
    q_n        = q_r;
    grant_port = 1'b0;
    case (state)
      IDLE: begin
        if (!guard_active) begin
          // A locked owner that has gone quiet gives up chip select first.
          if (lock && !holdv[owner] && !reqv[owner]) begin
            cs_n   = 1'b1;
            lock_n = 1'b0;
          end else if (cand != 2'b00) begin
            grant_port = (cand == 2'b11) ? ~last : cand[1];
            owner_n    = grant_port;
            last_n     = grant_port;
            spi_d_n    = grant_port ? bus.d1 : bus.d0;
            cs_n       = 1'b0;
            state_n    = LOAD;
          end
        end
      end
      LOAD: begin
        if (spi_ce) begin
          tick_n  = '0;
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        if (spi_ce) begin
          tick_n = tick + 5'd1;
          if (tick == 5'd15) state_n = DONE;
        end
      end
      DONE: begin
        q_n    = spi_q;
        lock_n = holdv[owner];
        if (!holdv[owner]) cs_n = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign spi_io   = (state == LOAD) && spi_ce;
  assign bus.ack0 = (state == DONE) && !owner;
  assign bus.ack1 = (state == DONE) && owner;
  assign bus.q    = (state == DONE) ? spi_q : q_r;
  assign bus.busy = guard_active || (state != IDLE);

endmodule

// File: tb/tb_spi_ctrl.sv
// Bench for spi_ctrl: a DIV=4 instance with an XOR-E5 engine model and a
// DIV=2 instance with a loopback engine, checked against scoreboard queues.
`timescale 1ns/1ps
module tb_spi_ctrl;

  typedef struct packed {
    logic       port;
    logic [7:0] data;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  spi_ctrl_if bus4 ();
  spi_ctrl_if bus2 ();

  logic       cs4, ce4, io4, cs2, ce2, io2;
  logic [7:0] sd4, sd2;
  logic [7:0] sq4 = 8'h00;
  logic [7:0] sq2 = 8'h00;

  spi_ctrl #(.DIV(4)) u4 (
    .clock(clock), .reset(reset), .bus(bus4),
    .cs(cs4), .spi_ce(ce4), .spi_io(io4), .spi_d(sd4), .spi_q(sq4)
  );

  spi_ctrl #(.DIV(2)) u2 (
    .clock(clock), .reset(reset), .bus(bus2),
    .cs(cs2), .spi_ce(ce2), .spi_io(io2), .spi_d(sd2), .spi_q(sq2)
  );

  exp_t sb4[$];
  exp_t sb2[$];
  int   checks   = 0;
  int   failures = 0;

  // Engine models: no reset, start on spi_io, return a byte after 16 ticks.
  logic       run4 = 1'b0, run2 = 1'b0;
  int         cnt4 = 0, cnt2 = 0;
  logic [7:0] tx4 = 8'h00, tx2 = 8'h00;

  always @(negedge clock) begin
    if (io4) begin
      run4 = 1'b1; cnt4 = 0; tx4 = sd4;
    end else if (run4 && ce4) begin
      cnt4++;
      if (cnt4 == 16) begin run4 = 1'b0; sq4 = tx4 ^ 8'hE5; end
    end
  end

  always @(negedge clock) begin
    if (io2) begin
      run2 = 1'b1; cnt2 = 0; tx2 = sd2;
    end else if (run2 && ce2) begin
      cnt2++;
      if (cnt2 == 16) begin run2 = 1'b0; sq2 = tx2; end
    end
  end

  int   io4_bad = 0, io2_cnt = 0, io2_bad = 0;
  logic io2_prev = 1'b0;
  always @(negedge clock) begin
    if (io4 && !ce4) io4_bad++;
    if (io2) begin
      io2_cnt++;
      if (!ce2 || io2_prev) io2_bad++;
    end
    io2_prev = io2;
  end

  initial begin
    #1ms;
    $display("[TB] FAIL watchdog simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  task automatic wait_ack(input int sel, input int budget, output logic port,
                          output logic [7:0] data, output int cycles,
                          output bit cs_high, output bit timeout);
    port = 1'b0; data = 8'h00; cycles = 0; cs_high = 1'b0; timeout = 1'b1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      cycles++;
      if (sel == 4) begin
        if (bus4.ack0 || bus4.ack1) begin
          port = bus4.ack1; data = bus4.q; timeout = 1'b0; break;
        end
        if (cs4) cs_high = 1'b1;
      end else begin
        if (bus2.ack0 || bus2.ack1) begin
          port = bus2.ack1; data = bus2.q; timeout = 1'b0; break;
        end
        if (cs2) cs_high = 1'b1;
      end
    end
  endtask

  task automatic guard_then_ack(input string name, output bit guard_bad,
                                output int first_io, output logic port,
                                output logic [7:0] data, output bit got);
    int ticks;
    ticks = 0; guard_bad = 1'b0; first_io = -1; got = 1'b0; port = 1'b0; data = 8'h00;
    for (int i = 0; i < 400; i++) begin
      @(negedge clock);
      if (ticks < 17 && (bus4.busy !== 1'b1 || cs4 !== 1'b1 || io4 !== 1'b0)) guard_bad = 1'b1;
      if (io4 && first_io < 0) first_io = ticks;
      if (ce4) ticks++;
      if (bus4.ack0 || bus4.ack1) begin
        got = 1'b1; port = bus4.ack1; data = bus4.q; break;
      end
    end
    checks++;
    if (guard_bad || first_io < 17) begin
      failures++;
      $display("[TB] FAIL %s_guard bad=%0d first_io_tick=%0d required bad=0 first_io_tick>=17",
               name, guard_bad, first_io);
    end
  endtask

  task automatic test_reset();
    bit guard_bad, got;
    int first_io;
    logic port;
    logic [7:0] data;
    exp_t e;
    repeat (3) @(negedge clock);
    checks++;
    if (cs4 !== 1'b1 || io4 !== 1'b0 || ce4 !== 1'b0 || sd4 !== 8'hFF || bus4.q !== 8'hFF ||
        bus4.ack0 !== 1'b0 || bus4.ack1 !== 1'b0 || bus4.busy !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reset_values cs=%b io=%b ce=%b spi_d=%h q=%h ack=%b%b busy=%b required 1 0 0 ff ff 00 1",
               cs4, io4, ce4, sd4, bus4.q, bus4.ack1, bus4.ack0, bus4.busy);
    end
    bus4.d0 = 8'h40; bus4.req0 = 1'b1;
    @(posedge clock); #1 reset = 1'b1;
    sb4.push_back('{1'b0, 8'h40 ^ 8'hE5});
    guard_then_ack("reset", guard_bad, first_io, port, data, got);
    e = sb4.pop_front();
    checks++;
    if (!got || port !== e.port || data !== e.data) begin
      failures++;
      $display("[TB] FAIL reset_first_byte got=%0d port=%0d q=%h required port=%0d q=%h",
               got, port, data, e.port, e.data);
    end
    @(posedge clock); #1 bus4.req0 = 1'b0;
    @(negedge clock);
    checks++;
    if (cs4 !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reset_cs_return cs=%b required 1", cs4);
    end
  endtask

  task automatic test_contention();
    logic port;
    logic [7:0] data;
    int cycles;
    bit cs_high, timeout;
    exp_t e;
    @(posedge clock); #1 reset = 1'b0;
    @(posedge clock); #1 reset = 1'b1;
    for (int i = 0; i < 200 && bus4.busy !== 1'b0; i++) @(negedge clock);
    @(posedge clock); #1;
    bus4.d0 = 8'h12; bus4.d1 = 8'h34; bus4.req0 = 1'b1; bus4.req1 = 1'b1;
    sb4.push_back('{1'b0, 8'h12 ^ 8'hE5});
    sb4.push_back('{1'b1, 8'h34 ^ 8'hE5});
    wait_ack(4, 200, port, data, cycles, cs_high, timeout);
    e = sb4.pop_front();
    checks++;
    if (timeout || port !== e.port || data !== e.data) begin
      failures++;
      $display("[TB] FAIL contention_first timeout=%0d port=%0d q=%h required port=%0d q=%h",
               timeout, port, data, e.port, e.data);
    end
    @(posedge clock); #1 bus4.req0 = 1'b0;
    wait_ack(4, 200, port, data, cycles, cs_high, timeout);
    e = sb4.pop_front();
    checks++;
    if (timeout || port !== e.port || data !== e.data || cs_high !== 1'b1) begin
      failures++;
      $display("[TB] FAIL contention_second timeout=%0d port=%0d q=%h cs_gap=%0d required port=%0d q=%h cs_gap=1",
               timeout, port, data, cs_high, e.port, e.data);
    end
    @(posedge clock); #1 bus4.req1 = 1'b0;
    wait_ack(4, 100, port, data, cycles, cs_high, timeout);
    checks++;
    if (!timeout) begin
      failures++;
      $display("[TB] FAIL contention_extra_ack port=%0d required no ack", port);
    end
  endtask

  task automatic test_lock();
    logic port;
    logic [7:0] data;
    int cycles;
    bit cs_high, timeout;
    exp_t e;
    @(posedge clock); #1;
    bus4.d1 = 8'h51; bus4.hold1 = 1'b1; bus4.req1 = 1'b1;
    sb4.push_back('{1'b1, 8'h51 ^ 8'hE5});
    repeat (4) @(posedge clock);
    #1 bus4.d0 = 8'h77; bus4.req0 = 1'b1;
    wait_ack(4, 200, port, data, cycles, cs_high, timeout);
    e = sb4.pop_front();
    checks++;
    if (timeout || port !== e.port || data !== e.data) begin
      failures++;
      $display("[TB] FAIL lock_first timeout=%0d port=%0d q=%h required port=%0d q=%h",
               timeout, port, data, e.port, e.data);
    end
    @(posedge clock); #1 bus4.d1 = 8'hFF;
    sb4.push_back('{1'b1, 8'hFF ^ 8'hE5});
    wait_ack(4, 200, port, data, cycles, cs_high, timeout);
    e = sb4.pop_front();
    checks++;
    if (timeout || port !== e.port || data !== e.data || cs_high !== 1'b0) begin
      failures++;
      $display("[TB] FAIL lock_owner_again timeout=%0d port=%0d q=%h cs_high=%0d required port=%0d q=%h cs_high=0",
               timeout, port, data, cs_high, e.port, e.data);
    end
    @(posedge clock); #1 bus4.req1 = 1'b0; bus4.hold1 = 1'b0;
    sb4.push_back('{1'b0, 8'h77 ^ 8'hE5});
    wait_ack(4, 200, port, data, cycles, cs_high, timeout);
    e = sb4.pop_front();
    checks++;
    if (timeout || port !== e.port || data !== e.data || cs_high !== 1'b1) begin
      failures++;
      $display("[TB] FAIL lock_release timeout=%0d port=%0d q=%h cs_gap=%0d required port=%0d q=%h cs_gap=1",
               timeout, port, data, cs_high, e.port, e.data);
    end
    @(posedge clock); #1 bus4.req0 = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic port;
    logic [7:0] data;
    int cycles;
    bit cs_high, timeout;
    exp_t e;
    @(posedge clock); #1;
    bus4.hold1 = 1'b1; bus4.req1 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bus4.d1 = 8'hA0 + 8'(k);
      sb4.push_back('{1'b1, (8'hA0 + 8'(k)) ^ 8'hE5});
      wait_ack(4, 200, port, data, cycles, cs_high, timeout);
      e = sb4.pop_front();
      checks++;
      if (timeout || port !== e.port || data !== e.data || cycles > 70 ||
          (k > 0 && cs_high !== 1'b0)) begin
        failures++;
        $display("[TB] FAIL back_to_back_%0d timeout=%0d port=%0d q=%h cycles=%0d cs_high=%0d required port=%0d q=%h cycles<=70 cs_high=0",
                 k, timeout, port, data, cycles, cs_high, e.port, e.data);
      end
      @(posedge clock); #1;
    end
    bus4.req1 = 1'b0; bus4.hold1 = 1'b0;
    repeat (3) @(negedge clock);
    checks++;
    if (cs4 !== 1'b1 || bus4.busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL back_to_back_release cs=%b busy=%b required cs=1 busy=0", cs4, bus4.busy);
    end
  endtask

  task automatic test_reset_mid_shift();
    bit guard_bad, got, seen;
    int first_io, ticks;
    logic port;
    logic [7:0] data;
    exp_t e;
    @(posedge clock); #1 bus4.d0 = 8'h99; bus4.req0 = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clock);
      if (io4) seen = 1'b1;
    end
    ticks = 0;
    for (int i = 0; i < 200 && ticks < 7; i++) begin
      @(negedge clock);
      if (ce4) ticks++;
    end
    @(posedge clock); #1 reset = 1'b0;
    #1;
    checks++;
    if (!seen || cs4 !== 1'b1 || bus4.ack0 !== 1'b0 || bus4.ack1 !== 1'b0 ||
        bus4.q !== 8'hFF || io4 !== 1'b0 || bus4.busy !== 1'b1) begin
      failures++;
      $display("[TB] FAIL mid_shift_reset started=%0d cs=%b ack=%b%b q=%h io=%b busy=%b required 1 1 00 ff 0 1",
               seen, cs4, bus4.ack1, bus4.ack0, bus4.q, io4, bus4.busy);
    end
    @(posedge clock); @(posedge clock); #1 reset = 1'b1;
    sb4.push_back('{1'b0, 8'h99 ^ 8'hE5});
    guard_then_ack("mid_shift", guard_bad, first_io, port, data, got);
    e = sb4.pop_front();
    checks++;
    if (!got || port !== e.port || data !== e.data) begin
      failures++;
      $display("[TB] FAIL mid_shift_retry got=%0d port=%0d q=%h required port=%0d q=%h",
               got, port, data, e.port, e.data);
    end
    @(posedge clock); #1 bus4.req0 = 1'b0;
  endtask

  task automatic test_div2();
    logic port;
    logic [7:0] data;
    int cycles, io_before;
    bit cs_high, timeout;
    exp_t e;
    io_before = io2_cnt;
    @(posedge clock); #1 bus2.d0 = 8'h3C; bus2.req0 = 1'b1;
    sb2.push_back('{1'b0, 8'h3C});
    wait_ack(2, 200, port, data, cycles, cs_high, timeout);
    e = sb2.pop_front();
    checks++;
    if (timeout || port !== e.port || data !== e.data) begin
      failures++;
      $display("[TB] FAIL div2_loopback timeout=%0d port=%0d q=%h required port=%0d q=%h",
               timeout, port, data, e.port, e.data);
    end
    checks++;
    if (io2_cnt - io_before !== 1 || io2_bad !== 0) begin
      failures++;
      $display("[TB] FAIL div2_io_pulse pulses=%0d misaligned=%0d required pulses=1 misaligned=0",
               io2_cnt - io_before, io2_bad);
    end
    @(posedge clock); #1 bus2.req0 = 1'b0; bus2.d1 = 8'hC3; bus2.req1 = 1'b1;
    sb2.push_back('{1'b1, 8'hC3});
    wait_ack(2, 200, port, data, cycles, cs_high, timeout);
    e = sb2.pop_front();
    checks++;
    if (timeout || port !== e.port || data !== e.data || cycles > 36) begin
      failures++;
      $display("[TB] FAIL div2_port1 timeout=%0d port=%0d q=%h cycles=%0d required port=%0d q=%h cycles<=36",
               timeout, port, data, cycles, e.port, e.data);
    end
    @(posedge clock); #1 bus2.req1 = 1'b0;
  endtask

  initial begin
    bus4.req0 = 1'b0; bus4.req1 = 1'b0; bus4.hold0 = 1'b0; bus4.hold1 = 1'b0;
    bus4.d0 = 8'h00; bus4.d1 = 8'h00;
    bus2.req0 = 1'b0; bus2.req1 = 1'b0; bus2.hold0 = 1'b0; bus2.hold1 = 1'b0;
    bus2.d0 = 8'h00; bus2.d1 = 8'h00;
    test_reset();
    test_contention();
    test_lock();
    test_back_to_back();
    test_reset_mid_shift();
    test_div2();
    checks++;
    if (io4_bad !== 0) begin
      failures++;
      $display("[TB] FAIL div4_io_alignment misaligned=%0d required 0", io4_bad);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_ctrl.md
# spi_ctrl

Byte-transfer controller that shares the SPI byte engine (SD card interface) between two requesters: port 0 is the boot/ROM loader and port 1 is the CPU I/O port. It generates the engine clock enable and issues the start strobe. It counts the engine's 16 half-bit ticks to detect completion, captures the received byte and manages the card chip select. A requester can hold chip select across several bytes (command plus data block) without the other port interleaving.

## Interface
- DIV, 4: spi_ce period in clocks; legal values 2..255.
- clock  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- req0, req1  in  1  byte request; a level held until the matching ack.
- hold0, hold1  in  1  keep chip select asserted after this byte (lock the engine to this port).
- d0, d1  in  8  byte to transmit; must be stable while req is high.
- ack0, ack1  out  1  one-clock pulse; the byte on that port is complete.
- q  out  8  last received byte; shared by both ports and valid while ack is high and until the next ack.
- busy  out  1  high while not in IDLE or during the post-reset guard.
- cs  out  1  card chip select, active-low.
- spi_ce  out  1  engine clock enable.
- spi_io  out  1  engine start strobe.
- spi_d  out  8  byte presented to the engine.
- spi_q  in  8  byte returned by the engine.

## Operation
- **Divider:** free-running, 0..DIV-1. spi_ce=1 for exactly one clock when the divider equals DIV-1.
- **Guard:** the engine has no reset.
  - After reset is released, the controller counts 17 spi_ce ticks before it grants anything.
  - busy=1 during the guard.
- **FSM states:** IDLE, LOAD, SHIFT, DONE.
- **IDLE:**
  - Eligible ports: if lock=1, only the owner is eligible; otherwise both are.
  - One eligible request: grant it.
  - Both eligible and requesting: grant the port that is not `last`.
  - On grant: owner:=i, last:=i, spi_d:=di, cs:=0, go to LOAD.
  - Release: if lock=1 and hold[owner]=0 with req[owner]=0, then cs:=1 and lock:=0 on the next clock. The state stays IDLE and nothing is granted in that same clock.
- **LOAD:**
  - spi_io = (state==LOAD) & spi_ce, so it is high for exactly one clock, coinciding with an spi_ce tick.
  - On that tick: tick counter:=0, go to SHIFT.
- **SHIFT:**
  - Increment the 5-bit tick counter on each spi_ce.
  - On the 16th tick, go to DONE.
  - spi_d holds its value throughout.
- **DONE (one clock):**
  - q:=spi_q; ack[owner]=1.
  - lock := hold[owner].
  - If hold[owner]=0, cs:=1.
  - Go to IDLE.
- **Back-to-back:** a requester that keeps req high through ack is re-arbitrated in the following IDLE clock as a new byte. A requester that wants no further byte drops req on the edge that ends DONE.
- **Data rules:** d/hold on a non-granted port are ignored. spi_q is read only in DONE.

## Timing
- **Reset values:**
  - cs=1, spi_io=0, spi_ce=0, spi_d=8'hFF, q=8'hFF, ack0=ack1=0, busy=1 (guard).
  - state=IDLE, lock=0, last=1 (port 0 wins the first contention), divider=0.
- **Reset mid-transfer:** all outputs go to their reset values immediately. The guard ensures the engine's in-flight byte (at most 16 ticks) drains before the next start.
- **Latency:**
  - Grant occurs 1 clock after req is sampled in IDLE.
  - spi_io follows 1..DIV clocks later.
  - DONE (ack) begins on the clock after the 16th spi_ce following the spi_io tick.
  - Total for DIV=4 with aligned divider: 17*DIV+2 = 70 clocks from req to ack at most.
- **Engine timing:**
  - The engine updates q on the falling edge within the 16th tick clock, so spi_q is stable at the DONE rising edge.
  - SPI bit rate = clock/(2*DIV).
- **Chip select:**
  - cs falls on the grant edge, at least one clock before spi_io.
  - cs rises on the edge ending DONE (hold=0) or on the release edge.
- **Simultaneous events:** a new req arriving during LOAD/SHIFT/DONE waits; there is no preemption. With lock=1, a non-owner req waits until release, however long.

## Test plan
- **Reset guard:**
  - Stimulus: deassert reset with req0=1, d0=8'h40, DIV=4.
  - Required: busy=1 and cs=1 for 17 spi_ce ticks. spi_io goes high only after the guard. ack0 arrives with q equal to the MISO model byte 8'hA5, and cs returns to 1.
- **Contention:**
  - Stimulus: req0=req1=1 simultaneously after the guard, hold=0.
  - Required: port 0 is served first (last=1), then port 1. Exactly one ack per port, in the order ack0 then ack1, and cs pulses high between the two bytes.
- **Lock:**
  - Stimulus: port 1 sends 8'h51 with hold1=1, then req0 rises.
  - Required: cs stays 0. Port 1's next byte 8'hFF is granted before port 0. Port 0 is granted only after port 1 drops hold1, with cs going high for at least 1 clock before port 0's cs=0.
- **Back-to-back:**
  - Stimulus: req1 held high through 3 acks with hold1=1.
  - Required: three bytes, each ack 17*DIV+2 clocks apart or less, and cs remains 0 throughout.
- **Reset mid-SHIFT:**
  - Stimulus: assert reset at tick 7 of a transfer.
  - Required: cs=1, ack=0 and q=8'hFF immediately. No spi_io occurs until 17 ticks after reset is released.
- **DIV=2 edge case:**
  - Required: the spi_io pulse is 1 clock wide and aligned to spi_ce, and the byte loops back correctly through a MISO=MOSI model (send 8'h3C, receive 8'h3C).
